// File: rtl/trdb_branch_map.sv
// rtl/trdb_branch_map.sv - taken/not-taken branch map feeding the packet-format selector
module trdb_branch_map #(
    parameter int MAX_BRANCHES = 31,
    parameter int CNT_W        = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    input  logic                    is_branch_i,
    input  logic                    branch_taken_i,
    input  logic                    flush_i,
    output logic [MAX_BRANCHES-1:0] map_o,
    output logic [CNT_W-1:0]        branches_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    overflow_o
);

    logic [MAX_BRANCHES-1:0] map_d, map_q;
    logic [CNT_W-1:0]        branches_d, branches_q;
    logic                    overflow_d, overflow_q;
    logic                    rec;
    logic                    full;
    logic [MAX_BRANCHES-1:0] new_bit;

    assign rec     = valid_i & is_branch_i;
    assign full    = (branches_q == CNT_W'(MAX_BRANCHES));
    // E-trace encodes not-taken as 1
    assign new_bit = {{(MAX_BRANCHES-1){1'b0}}, ~branch_taken_i};

    always_comb begin
        map_d      = map_q;
        branches_d = branches_q;
        overflow_d = 1'b0;
        if (flush_i) begin
            // the flushed contents belong to the packet just emitted
            map_d      = rec ? new_bit : '0;
            branches_d = rec ? CNT_W'(1) : '0;
        end else if (rec) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                map_d      = map_q | (new_bit << branches_q);
                branches_d = branches_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q      <= '0;
            branches_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            map_q      <= map_d;
            branches_q <= branches_d;
            overflow_q <= overflow_d;
        end
    end

    assign map_o      = map_q;
    assign branches_o = branches_q;
    assign overflow_o = overflow_q;
    assign empty_o    = (branches_q == '0);
    assign full_o     = full;

endmodule

// File: tb/tb_trdb_branch_map.sv
// tb/tb_trdb_branch_map.sv - directed bench with queue-based reference model
module tb_trdb_branch_map;

    localparam int MAXB = 31;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid = 1'b0, is_br = 1'b0, taken = 1'b0, flush = 1'b0;
    logic [MAXB-1:0] map_o;
    logic [4:0]      branches_o;
    logic            empty_o, full_o, overflow_o;

    int checks = 0;
    int errors = 0;

    trdb_branch_map #(.MAX_BRANCHES(MAXB), .CNT_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .is_branch_i(is_br),
        .branch_taken_i(taken), .flush_i(flush), .map_o(map_o),
        .branches_o(branches_o), .empty_o(empty_o), .full_o(full_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // reference model: ordered list of recorded outcome bits (1 = not taken)
    bit mq[$];
    bit m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b0;
            if (flush) begin
                mq.delete();
                if (valid && is_br) mq.push_back(!taken);
            end else if (valid && is_br) begin
                if (mq.size() < MAXB) mq.push_back(!taken);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [MAXB-1:0] em;
        em = '0;
        for (int i = 0; i < mq.size(); i++) em[i] = mq[i];
        chk("model map", 64'(map_o), 64'(em));
        chk("model branches", 64'(branches_o), 64'(mq.size()));
        chk("model empty", 64'(empty_o), 64'(mq.size() == 0));
        chk("model full", 64'(full_o), 64'(mq.size() == MAXB));
        chk("model overflow", 64'(overflow_o), 64'(m_ovf));
    end

    task automatic step(input logic v, input logic b, input logic t, input logic f);
        valid = v; is_br = b; taken = t; flush = f;
        @(posedge clk);
        #1;
        valid = 1'b0; is_br = 1'b0; taken = 1'b0; flush = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset map", 64'(map_o), 64'h0);
        chk("reset branches", 64'(branches_o), 64'h0);
        chk("reset empty", 64'(empty_o), 64'h1);
        chk("reset full", 64'(full_o), 64'h0);
        chk("reset overflow", 64'(overflow_o), 64'h0);
        rst_n = 1'b1;

        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("three branches count", 64'(branches_o), 64'd3);
        chk("three branches map", 64'(map_o), 64'b110);
        chk("three branches empty", 64'(empty_o), 64'h0);
        chk("three branches full", 64'(full_o), 64'h0);

        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, i[0], 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        chk("non-branch count", 64'(branches_o), 64'd0);
        chk("non-branch empty", 64'(empty_o), 64'h1);

        for (int i = 0; i < MAXB; i++) step(1, 1, 0, 0);
        chk("full count", 64'(branches_o), 64'd31);
        chk("full map", 64'(map_o), 64'h7FFF_FFFF);
        chk("full flag", 64'(full_o), 64'h1);
        step(1, 1, 1, 0);
        chk("overflow pulse", 64'(overflow_o), 64'h1);
        chk("overflow count", 64'(branches_o), 64'd31);
        chk("overflow map", 64'(map_o), 64'h7FFF_FFFF);
        step(0, 0, 0, 0);
        chk("overflow one cycle", 64'(overflow_o), 64'h0);

        step(1, 1, 1, 1);
        chk("flush+rec count", 64'(branches_o), 64'd1);
        chk("flush+rec map", 64'(map_o), 64'h0);
        chk("flush+rec full", 64'(full_o), 64'h0);
        chk("flush+rec overflow", 64'(overflow_o), 64'h0);

        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        chk("five branches map", 64'(map_o), 64'b10101);
        step(0, 0, 0, 1);
        chk("flush count", 64'(branches_o), 64'd0);
        chk("flush map", 64'(map_o), 64'h0);
        chk("flush empty", 64'(empty_o), 64'h1);
        step(0, 0, 0, 1);
        chk("flush empty again count", 64'(branches_o), 64'd0);
        chk("flush empty again map", 64'(map_o), 64'h0);

        for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
        chk("seven branches count", 64'(branches_o), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset map", 64'(map_o), 64'h0);
        chk("async reset branches", 64'(branches_o), 64'h0);
        chk("async reset empty", 64'(empty_o), 64'h1);
        chk("async reset overflow", 64'(overflow_o), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 1, 0, 0);
        chk("post reset count", 64'(branches_o), 64'd1);
        chk("post reset map", 64'(map_o), 64'h1);

        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trdb_branch_map.md
Name: trdb_branch_map

Overview:
- Collects the taken/not-taken outcome of every qualified retired branch into a shift-free bit map.
- Sits directly upstream of the packet-format selector: supplies the branch-map-empty and branch-map-full flags, plus the map contents and branch count used by format 0/1/2 packets.
- Cleared by a flush request from the selector/packet emitter whenever a packet carrying the branch map is emitted.

Parameters:
- MAX_BRANCHES, 31, capacity of the map in branches (E-trace maximum).
- CNT_W, 5, width of the branch counter; must satisfy 2**CNT_W > MAX_BRANCHES.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  a qualified instruction retires this cycle.
- is_branch_i  input  1  the retiring instruction is a conditional branch.
- branch_taken_i  input  1  branch outcome; 1 = taken.
- flush_i  input  1  the downstream packet consumed map_o/branches_o this cycle; clear the map.
- map_o  output  MAX_BRANCHES  branch map; bit i = outcome of the i-th recorded branch, 1 = NOT taken, 0 = taken (E-trace encoding). Bits at or above branches_o read 0.
- branches_o  output  CNT_W  number of valid bits in map_o (0..MAX_BRANCHES).
- empty_o  output  1  branches_o == 0.
- full_o  output  1  branches_o == MAX_BRANCHES.
- overflow_o  output  1  one-cycle pulse: a branch was dropped because the map was full and not flushed.

Behaviour:
- Reset (async, rst_ni=0): map=0, branches=0, empty_o=1, full_o=0, overflow_o=0. Release is synchronous to clk_i.
- All outputs are registered, except that empty_o and full_o are decoded combinationally from the branch counter register.
- Record event: rec = valid_i & is_branch_i. is_branch_i and branch_taken_i are ignored when valid_i=0.
- Next-state rules per cycle, in priority order:
  - flush_i & rec: map <= {0.., ~branch_taken_i} (new branch goes into bit 0); branches <= 1. The old contents were consumed this cycle; the new branch belongs to the next packet.
  - flush_i & !rec: map <= 0; branches <= 0.
  - !flush_i & rec & !full: map[branches] <= ~branch_taken_i; branches <= branches+1.
  - !flush_i & rec & full: map and count are unchanged; overflow_o <= 1 for one cycle. This is an upstream protocol error; the selector must flush in any cycle where full_o=1 and a branch retires.
  - Otherwise: hold.
- Latency: an outcome recorded in cycle N is visible on map_o/branches_o/empty_o in cycle N+1.
- The branch counter saturates at MAX_BRANCHES and never wraps.
- flush_i with an empty map is legal and has no effect beyond holding zeros.
- Reset mid-fill discards all recorded outcomes without generating overflow.
- No other outputs change while valid_i=0.

Test Plan:
- Reset, then 3 branches (taken, not-taken, not-taken), no flush -> after last edge: branches_o=3, map_o=0b110, empty_o=0, full_o=0.
- valid_i=1 with is_branch_i=0 for 10 cycles, plus valid_i=0 with is_branch_i=1 -> branches_o stays 0, empty_o=1.
- 31 not-taken branches -> branches_o=31, map_o=0x7FFF_FFFF, full_o=1. A 32nd branch (taken) without flush -> overflow_o pulses high one cycle; map_o and branches_o unchanged.
- Full map; flush_i=1 with a simultaneous taken branch -> next cycle branches_o=1, map_o=0, full_o=0, overflow_o=0.
- 5 branches, then flush_i alone -> branches_o=0, map_o=0, empty_o=1. A further flush while empty -> no change.
- 7 branches recorded, then rst_ni asserted asynchronously mid-cycle -> outputs go to reset values immediately without a clock edge; first branch after release lands in bit 0.
